// File: rtl/sar_pkg.sv
// Shared SAR definitions: code width, averaging defaults and the code type
// used by both the conversion logic and its downstream consumers.
package sar_pkg;

   localparam int SAR_DATA_W    = 4;
   localparam int SAR_LOG2_AVG  = 2;
   localparam int SAR_THRESH_HI = 10;
   localparam int SAR_THRESH_LO = 6;

   typedef logic [SAR_DATA_W-1:0] sar_code_t;

endpackage

// File: rtl/sar_out_buffer.sv
// One-entry valid/ready holding register; a load that finds the entry full and
// not being drained is dropped and reported with a single-cycle drop pulse.
module sar_out_buffer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] data,
   output logic         drop
);

   logic accept;

   // A draining handshake frees the slot in the same cycle, so a new load may
   // replace the outgoing entry without a bubble.
   assign accept = load & (~valid | ready);
   assign drop   = load & valid & ~ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (accept) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (valid & ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/sar_sample_averager.sv
// Captures one SAR code per conv_done rising edge, block-averages 2^LOG2_AVG
// codes, and publishes each average with a hysteresis flag and sticky overrun.
module sar_sample_averager
   import sar_pkg::*;
#(
   parameter int DATA_W    = SAR_DATA_W,
   parameter int LOG2_AVG  = SAR_LOG2_AVG,
   parameter int THRESH_HI = SAR_THRESH_HI,
   parameter int THRESH_LO = SAR_THRESH_LO
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] bitout,
   input  logic              conv_done,
   output logic [DATA_W-1:0] avg_data,
   output logic              avg_valid,
   input  logic              avg_ready,
   output logic              above,
   output logic              overrun,
   input  logic              clear_overrun
);

   localparam int ACC_W = DATA_W + LOG2_AVG;
   localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;

   // Overlapping thresholds would make the hysteresis band meaningless.
   if (THRESH_LO >= THRESH_HI) begin : g_bad_thresh
      $error("sar_sample_averager: THRESH_LO must be below THRESH_HI");
   end

   logic              conv_done_q;
   logic              rise;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  sum;
   logic [CNT_W-1:0]  count;
   logic              last_sample;
   logic              result_evt;
   logic [DATA_W-1:0] result;
   logic              drop;

   assign rise        = conv_done & ~conv_done_q;
   assign sum         = acc + ACC_W'(bitout);
   assign last_sample = (count == CNT_W'((1 << LOG2_AVG) - 1));
   assign result_evt  = rise & last_sample;
   assign result      = sum[ACC_W-1:LOG2_AVG];

   // conv_done_q resets high so a conversion already finished when reset
   // releases is not mistaken for a fresh one.
   always_ff @(posedge clk) begin
      if (reset) begin
         conv_done_q <= 1'b1;
         acc         <= '0;
         count       <= '0;
         above       <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         conv_done_q <= conv_done;
         if (rise) begin
            if (last_sample) begin
               acc   <= '0;
               count <= '0;
               if (result >= DATA_W'(THRESH_HI)) begin
                  above <= 1'b1;
               end else if (result <= DATA_W'(THRESH_LO)) begin
                  above <= 1'b0;
               end
            end else begin
               acc   <= sum;
               count <= count + CNT_W'(1);
            end
         end
         if (drop) begin
            overrun <= 1'b1;
         end else if (clear_overrun) begin
            overrun <= 1'b0;
         end
      end
   end

   sar_out_buffer #(
      .W(DATA_W)
   ) u_out_buffer (
      .clk       (clk),
      .reset     (reset),
      .load      (result_evt),
      .load_data (result),
      .ready     (avg_ready),
      .valid     (avg_valid),
      .data      (avg_data),
      .drop      (drop)
   );

endmodule

// File: tb/tb_sar_sample_averager.sv
// Directed bench for sar_sample_averager: averaging, hysteresis, long
// conv_done pulses, overrun handling, simultaneous handshake and mid-block reset.
module tb_sar_sample_averager;

   logic       clk;
   logic       reset;
   logic [3:0] bitout;
   logic       conv_done;
   logic [3:0] avg_data;
   logic       avg_valid;
   logic       avg_ready;
   logic       above;
   logic       overrun;
   logic       clear_overrun;

   int total;
   int bad;

   sar_sample_averager dut (
      .clk           (clk),
      .reset         (reset),
      .bitout        (bitout),
      .conv_done     (conv_done),
      .avg_data      (avg_data),
      .avg_valid     (avg_valid),
      .avg_ready     (avg_ready),
      .above         (above),
      .overrun       (overrun),
      .clear_overrun (clear_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Raise conv_done with a code; returns right after the capturing edge.
   task automatic applyStimulus(input logic [3:0] code);
      conv_done = 1'b1;
      bitout    = code;
      step();
   endtask

   task automatic releaseConv(input int extra_high);
      repeat (extra_high) step();
      conv_done = 1'b0;
      bitout    = '0;
      step();
   endtask

   task automatic pulse(input logic [3:0] code, input int hold);
      applyStimulus(code);
      releaseConv(hold - 1);
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      reset         = 1'b1;
      bitout        = '0;
      conv_done     = 1'b0;
      avg_ready     = 1'b1;
      clear_overrun = 1'b0;
      step();
      step();
      checkOutput("rst_valid", avg_valid, 0);
      checkOutput("rst_data", avg_data, 0);
      checkOutput("rst_above", above, 0);
      checkOutput("rst_overrun", overrun, 0);
      reset = 1'b0;
      step();

      // Basic average: (3+5+7+9)/4 = 6
      pulse(4'd3, 1);
      pulse(4'd5, 1);
      pulse(4'd7, 1);
      checkOutput("avg1_not_yet", avg_valid, 0);
      applyStimulus(4'd9);
      checkOutput("avg1_valid", avg_valid, 1);
      checkOutput("avg1_data", avg_data, 6);
      checkOutput("avg1_above", above, 0);
      releaseConv(0);
      checkOutput("avg1_valid_drop", avg_valid, 0);
      checkOutput("avg1_data_hold", avg_data, 6);

      // Hysteresis: 59>>2 = 14 sets, 8 holds, 20>>2 = 5 clears
      pulse(4'd15, 1);
      pulse(4'd15, 1);
      pulse(4'd15, 1);
      applyStimulus(4'd14);
      checkOutput("hys1_data", avg_data, 14);
      checkOutput("hys1_above", above, 1);
      releaseConv(0);
      pulse(4'd8, 1);
      pulse(4'd8, 1);
      pulse(4'd8, 1);
      applyStimulus(4'd8);
      checkOutput("hys2_data", avg_data, 8);
      checkOutput("hys2_above", above, 1);
      releaseConv(0);
      pulse(4'd4, 1);
      pulse(4'd4, 1);
      pulse(4'd6, 1);
      applyStimulus(4'd6);
      checkOutput("hys3_data", avg_data, 5);
      checkOutput("hys3_above", above, 0);
      releaseConv(0);

      // Long conv_done pulses: one capture per pulse only
      pulse(4'd2, 10);
      pulse(4'd2, 10);
      checkOutput("long_mid_valid", avg_valid, 0);
      pulse(4'd2, 10);
      applyStimulus(4'd2);
      checkOutput("long_valid", avg_valid, 1);
      checkOutput("long_data", avg_data, 2);
      step();
      checkOutput("long_one_cycle", avg_valid, 0);
      releaseConv(8);
      checkOutput("long_no_extra", avg_valid, 0);
      pulse(4'd4, 1);
      pulse(4'd4, 1);
      pulse(4'd4, 1);
      checkOutput("long_align_pre", avg_valid, 0);
      applyStimulus(4'd4);
      checkOutput("long_align_valid", avg_valid, 1);
      checkOutput("long_align_data", avg_data, 4);
      releaseConv(0);

      // Overrun: full buffer drops the second result
      avg_ready = 1'b0;
      pulse(4'd6, 1);
      pulse(4'd6, 1);
      pulse(4'd6, 1);
      applyStimulus(4'd6);
      checkOutput("ovr_first_data", avg_data, 6);
      checkOutput("ovr_first_overrun", overrun, 0);
      releaseConv(0);
      checkOutput("ovr_hold_valid", avg_valid, 1);
      pulse(4'd2, 1);
      pulse(4'd2, 1);
      pulse(4'd2, 1);
      applyStimulus(4'd2);
      checkOutput("ovr_data_kept", avg_data, 6);
      checkOutput("ovr_valid", avg_valid, 1);
      checkOutput("ovr_flag", overrun, 1);
      checkOutput("ovr_above", above, 0);
      releaseConv(0);
      avg_ready = 1'b1;
      step();
      checkOutput("ovr_drain_valid", avg_valid, 0);
      checkOutput("ovr_drain_data", avg_data, 6);
      checkOutput("ovr_sticky", overrun, 1);
      clear_overrun = 1'b1;
      step();
      clear_overrun = 1'b0;
      checkOutput("ovr_cleared", overrun, 0);

      // Simultaneous handshake and new result
      avg_ready = 1'b0;
      pulse(4'd6, 1);
      pulse(4'd6, 1);
      pulse(4'd6, 1);
      pulse(4'd6, 1);
      checkOutput("sim_pre_data", avg_data, 6);
      pulse(4'd3, 1);
      pulse(4'd3, 1);
      pulse(4'd3, 1);
      avg_ready = 1'b1;
      applyStimulus(4'd3);
      checkOutput("sim_data", avg_data, 3);
      checkOutput("sim_valid", avg_valid, 1);
      checkOutput("sim_overrun", overrun, 0);
      releaseConv(0);
      checkOutput("sim_drain", avg_valid, 0);

      // Reset mid-block with conv_done high at release
      pulse(4'd15, 1);
      pulse(4'd15, 1);
      conv_done = 1'b1;
      bitout    = 4'd15;
      reset     = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
      step();
      checkOutput("rst2_valid", avg_valid, 0);
      checkOutput("rst2_data", avg_data, 0);
      releaseConv(0);
      pulse(4'd1, 1);
      pulse(4'd1, 1);
      pulse(4'd1, 1);
      checkOutput("rst2_partial_gone", avg_valid, 0);
      applyStimulus(4'd1);
      checkOutput("rst2_valid_res", avg_valid, 1);
      checkOutput("rst2_data_res", avg_data, 1);
      checkOutput("rst2_above", above, 0);
      releaseConv(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sar_sample_averager.md
Name: sar_sample_averager

Overview:
Downstream consumer of the SAR conversion logic. It captures each finished conversion code (bitout) when conv_done rises. It block-averages 2^LOG2_AVG codes and presents each average through a one-entry valid/ready output buffer. It also keeps a hysteresis threshold flag and a sticky overrun flag, so slow readers (pin-level or a later serialiser) see stable data.

Parameters:
DATA_W, 4, width of the SAR code; matches bitout of the SAR logic
LOG2_AVG, 2, log2 of block size; 0 = pass-through (every code is a result)
THRESH_HI, 10, average >= this sets above
THRESH_LO, 6, average <= this clears above; THRESH_LO < THRESH_HI is required (elaboration check)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
bitout  input  DATA_W  SAR conversion code, valid while conv_done high
conv_done  input  1  SAR done level; may stay high for many cycles
avg_data  output  DATA_W  averaged code, stable while avg_valid=1
avg_valid  output  1  output buffer holds a result
avg_ready  input  1  consumer accepts avg_data when avg_valid & avg_ready
above  output  1  hysteresis threshold flag
overrun  output  1  sticky: a result was dropped because the buffer was full
clear_overrun  input  1  clears overrun

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - avg_data=0, avg_valid=0, above=0, overrun=0.
  - Accumulator=0, sample count=0.
  - conv_done_q=1, so a conv_done already high at reset release is not captured.
- Capture:
  - rise = conv_done & ~conv_done_q; conv_done_q <= conv_done every cycle.
  - On a rise cycle, bitout is sampled at that clock edge.
  - One capture per rise, whatever the high duration.
- Accumulate:
  - acc is DATA_W+LOG2_AVG bits wide, so no overflow is possible.
  - count is LOG2_AVG bits and wraps.
  - On capture with count != 2^LOG2_AVG-1: acc += bitout, count++.
  - On capture with count == 2^LOG2_AVG-1: result = (acc + bitout) >> LOG2_AVG (truncate, no rounding); acc <= 0, count <= 0; a result event is raised.
- Latency: avg_valid/avg_data update at the same clock edge that samples the final code, i.e. visible one cycle after conv_done is seen high.
- Output buffer (one entry):
  - Load on a result event when avg_valid=0, or avg_valid=1 & avg_ready=1 (simultaneous handshake and new result: new data loaded, avg_valid stays 1, no overrun).
  - Result event while avg_valid=1 & avg_ready=0: result dropped, avg_data unchanged, overrun <= 1.
  - Handshake with no new result: avg_valid <= 0 next edge; avg_data holds its last value.
- above: updated on every result event, accepted or dropped.
  - result >= THRESH_HI sets it.
  - result <= THRESH_LO clears it.
  - Otherwise it holds.
  - Changes at the same edge as the result event.
- overrun: clear_overrun=1 clears it; a simultaneous new drop wins (stays 1).
- Reset mid-block: the partial accumulation is discarded and the next block starts from count 0.
- No other state machine; count plus buffer valid form the control state.

Decomposition:
- Shared package sar_pkg:
  - SAR_DATA_W=4.
  - Default LOG2_AVG, THRESH_HI and THRESH_LO constants.
  - sar_code_t typedef (logic [SAR_DATA_W-1:0]), shared with the SAR logic.
- One sub-module is natural: sar_out_buffer.
  - Generic one-entry valid/ready register.
  - Inputs: load request plus data.
  - Outputs: valid, data, drop pulse (the overrun source).
- Edge detect, accumulator and hysteresis stay inline.

Test Plan:
- Defaults, avg_ready=1: codes 3,5,7,9 on four conv_done pulses -> avg_data=6, avg_valid high exactly one cycle, one cycle after the 4th conv_done is seen high; above=0.
- Hysteresis: blocks {15,15,15,14} -> 14, above=1; {8,8,8,8} -> 8, above stays 1; {4,4,6,6} -> 5, above=0.
- conv_done held high 10 cycles per pulse, codes 2,2,2,2 -> exactly one result of 2; no extra captures.
- avg_ready=0: block avg 6, then block {2,2,2,2} -> avg_data stays 6, overrun=1. Then avg_ready=1 -> valid drops. Then clear_overrun pulse -> overrun=0.
- Simultaneous: avg_valid=1 holding 6, avg_ready=1 in the same cycle as new result 3 -> avg_data=3, avg_valid stays 1, overrun=0.
- Reset after 2 captures (codes 15,15); conv_done high when reset releases -> no capture. Then codes 1,1,1,1 -> result 1; the partial block is discarded.
